// File: rtl/riscv_pkg.sv
// riscv_pkg: state encoding, opcodes and datapath mux-select encodings
// shared by the multicycle controller and its bench-facing users.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10;
    localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;

    localparam logic [2:0] RES_ALUOUT = 3'b000, RES_MEM = 3'b001, RES_ALU = 3'b010;
    localparam logic [2:0] RES_IMM = 3'b011, RES_PCIMM = 3'b100;

    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011, IMM_U = 3'b100;

    // Unknown opcodes map to S_FETCH, which the controller treats as illegal.
    function automatic state_t decode_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_R:              return S_EXECR;
            OP_I:              return S_EXECI;
            OP_BRANCH:         return S_BRANCH;
            OP_JAL:            return S_JAL;
            OP_JALR:           return S_JALR;
            OP_LUI:            return S_LUI;
            OP_AUIPC:          return S_AUIPC;
            default:           return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts unacknowledged memory-request cycles and flags the
// cycle in which the count reaches LIMIT.
module mem_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    output logic timeout
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    assign timeout = waiting && (count == W'(LIMIT - 1));

    // Any non-waiting cycle (or the timeout itself) precedes entry into a new
    // request state, so the count is always zero when a request begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= (waiting && !timeout) ? count + 1'b1 : '0;
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RISC-V multicycle control FSM with memory-wait
// timeout and illegal-opcode detection.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op_type,
    output logic [2:0] result_src,
    output logic [2:0] immsrc,
    output logic       illegal,
    output logic       bus_error
);
    state_t state, next;
    logic   active, ack, timeout;

    // active holds requests off during reset and until the first clock after release.
    assign mem_req   = active && (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE);
    assign ack       = mem_req && mem_ready;
    assign bus_error = timeout;

    mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .waiting(mem_req && !mem_ready),
        .timeout(timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            active <= 1'b0;
        end else begin
            state  <= next;
            active <= 1'b1;
        end
    end

    always_comb begin
        next        = state;
        mem_we      = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_op_type = ALU_ADD;
        result_src  = RES_ALUOUT;
        immsrc      = IMM_I;
        illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                ir_write  = ack;
                pc_write  = ack;
                next      = ack ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                immsrc    = IMM_B;
                next      = decode_op(op);
                illegal   = (decode_op(op) == S_FETCH);
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                immsrc    = (op == OP_STORE) ? IMM_S : IMM_I;
                next      = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                next    = ack ? S_MEMWB : timeout ? S_FETCH : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                next       = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_we  = 1'b1;
                adr_src = 1'b1;
                next    = (ack || timeout) ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = (state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
                alu_op_type = ALU_FUNCT;
                next        = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                next      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = SRCA_RS1;
                alu_op_type = ALU_SUB;
                pc_write    = zero;
                next        = S_FETCH;
            end
            S_JAL: begin
                immsrc    = IMM_J;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                next      = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                next       = S_FETCH;
            end
            S_LUI, S_AUIPC: begin
                immsrc     = IMM_U;
                result_src = (state == S_LUI) ? RES_IMM : RES_PCIMM;
                reg_write  = 1'b1;
                next       = S_FETCH;
            end
            default: next = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven per-cycle check of all controller
// outputs, plus hand-written reset and reset-mid-access sequences.
module tb_multicycle_controller;
    logic       clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [6:0] op = 7'h00;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal, bus_error;
    logic [1:0] alu_src_a, alu_src_b, alu_op_type;
    logic [2:0] result_src, immsrc;
    logic [19:0] act;

    localparam logic [6:0] LD = 7'h03, ST = 7'h23, RR = 7'h33, II = 7'h13, BR = 7'h63;
    localparam logic [6:0] JL = 7'h6F, JR = 7'h67, LU = 7'h37, AU = 7'h17, BAD = 7'h7F;

    typedef struct {
        logic [6:0]  op;
        logic        zero;
        logic        ready;
        logic [19:0] exp;
    } vec_t;

    vec_t        tv[$];
    logic [19:0] sb[$];
    int          checks = 0, errors = 0;

    multicycle_controller #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op_type(alu_op_type), .result_src(result_src),
        .immsrc(immsrc), .illegal(illegal), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    assign act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, alu_src_a,
                  alu_src_b, alu_op_type, result_src, immsrc, illegal, bus_error};

    function automatic logic [19:0] o(input logic mreq, we, adr, irw, pcw, rw,
                                      input logic [1:0] a, b, alu,
                                      input logic [2:0] res, imm,
                                      input logic ill, be);
        return {mreq, we, adr, irw, pcw, rw, a, b, alu, res, imm, ill, be};
    endfunction

    task automatic chk(input string nm);
        logic [19:0] x;
        x = sb.pop_front();
        checks++;
        if (act !== x) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", nm, act, x);
        end
    endtask

    task automatic step(input logic [6:0] p, input logic z, input logic r,
                        input logic [19:0] e, input string nm);
        op = p; zero = z; mem_ready = r;
        sb.push_back(e);
        @(negedge clk);
        chk(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [6:0] p, input logic z, input logic r, input logic [19:0] e);
        tv.push_back('{op: p, zero: z, ready: r, exp: e});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] e_rst, e_fw, e_fg, e_fto, e_dec, e_ill, e_mal, e_mas, e_mr, e_wb;
        logic [19:0] e_mw, e_mwto, e_exr, e_exi, e_awb, e_bt, e_bn, e_jal, e_jalr, e_lui, e_aui;
        e_rst  = o(0,0,0,0,0,0, 2'b00,2'b10,2'b00, 3'b000,3'b000, 0,0);
        e_fw   = o(1,0,0,0,0,0, 2'b00,2'b10,2'b00, 3'b000,3'b000, 0,0);
        e_fg   = o(1,0,0,1,1,0, 2'b00,2'b10,2'b00, 3'b000,3'b000, 0,0);
        e_fto  = o(1,0,0,0,0,0, 2'b00,2'b10,2'b00, 3'b000,3'b000, 0,1);
        e_dec  = o(0,0,0,0,0,0, 2'b01,2'b01,2'b00, 3'b000,3'b010, 0,0);
        e_ill  = o(0,0,0,0,0,0, 2'b01,2'b01,2'b00, 3'b000,3'b010, 1,0);
        e_mal  = o(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b000,3'b000, 0,0);
        e_mas  = o(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b000,3'b001, 0,0);
        e_mr   = o(1,0,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000,3'b000, 0,0);
        e_wb   = o(0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b001,3'b000, 0,0);
        e_mw   = o(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000,3'b000, 0,0);
        e_mwto = o(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000,3'b000, 0,1);
        e_exr  = o(0,0,0,0,0,0, 2'b10,2'b00,2'b10, 3'b000,3'b000, 0,0);
        e_exi  = o(0,0,0,0,0,0, 2'b10,2'b01,2'b10, 3'b000,3'b000, 0,0);
        e_awb  = o(0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000,3'b000, 0,0);
        e_bt   = o(0,0,0,0,1,0, 2'b10,2'b00,2'b01, 3'b000,3'b000, 0,0);
        e_bn   = o(0,0,0,0,0,0, 2'b10,2'b00,2'b01, 3'b000,3'b000, 0,0);
        e_jal  = o(0,0,0,0,1,1, 2'b00,2'b00,2'b00, 3'b000,3'b011, 0,0);
        e_jalr = o(0,0,0,0,1,1, 2'b10,2'b01,2'b00, 3'b010,3'b000, 0,0);
        e_lui  = o(0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b011,3'b100, 0,0);
        e_aui  = o(0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b100,3'b100, 0,0);

        // R-type, with mem_ready high in non-memory states to show it is ignored
        add(RR,0,1,e_fg); add(RR,0,1,e_dec); add(RR,0,1,e_exr); add(RR,0,1,e_awb);
        add(II,0,1,e_fg); add(II,0,0,e_dec); add(II,0,0,e_exi); add(II,0,0,e_awb);
        // lw: one fetch wait, then MEMREAD x4 with ready on the 4th
        add(LD,0,0,e_fw); add(LD,0,1,e_fg); add(LD,0,0,e_dec); add(LD,0,1,e_mal);
        add(LD,0,0,e_mr); add(LD,0,0,e_mr); add(LD,0,0,e_mr); add(LD,0,1,e_mr);
        add(LD,0,1,e_wb);
        add(ST,0,1,e_fg); add(ST,0,0,e_dec); add(ST,0,0,e_mas); add(ST,0,1,e_mw);
        add(BR,1,1,e_fg); add(BR,1,0,e_dec); add(BR,1,0,e_bt);
        add(BR,0,1,e_fg); add(BR,0,0,e_dec); add(BR,0,0,e_bn);
        add(JL,0,1,e_fg); add(JL,0,0,e_dec); add(JL,0,0,e_jal);
        add(JR,0,1,e_fg); add(JR,0,0,e_dec); add(JR,0,0,e_jalr);
        add(LU,0,1,e_fg); add(LU,0,0,e_dec); add(LU,0,0,e_lui);
        add(AU,0,1,e_fg); add(AU,0,0,e_dec); add(AU,0,0,e_aui);
        add(BAD,0,1,e_fg); add(BAD,0,1,e_ill); add(BAD,0,0,e_fw);
        // FETCH timeout stays in FETCH, then succeeds
        add(RR,0,0,e_fw); add(RR,0,0,e_fw); add(RR,0,0,e_fto); add(RR,0,0,e_fw);
        add(RR,0,1,e_fg); add(RR,0,0,e_dec); add(RR,0,0,e_exr); add(RR,0,0,e_awb);
        // sw timeout: bus_error on the 4th wait cycle, then FETCH with mem_we low
        add(ST,0,1,e_fg); add(ST,0,0,e_dec); add(ST,0,0,e_mas);
        add(ST,0,0,e_mw); add(ST,0,0,e_mw); add(ST,0,0,e_mw); add(ST,0,0,e_mwto);
        add(ST,0,0,e_fw);

        mem_ready = 1'b1;
        #3;
        sb.push_back(e_rst); chk("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sb.push_back(e_rst); chk("post_release_mask");
        @(posedge clk);
        #1;

        foreach (tv[i])
            step(tv[i].op, tv[i].zero, tv[i].ready, tv[i].exp, $sformatf("vec%0d", i));

        // Reset during MEMREAD abandons the access
        step(LD,0,1,e_fg,"rst_fetch"); step(LD,0,0,e_dec,"rst_dec");
        step(LD,0,0,e_mal,"rst_madr"); step(LD,0,0,e_mr,"rst_mr_wait");
        mem_ready = 1'b0;
        sb.push_back(e_mr); chk("rst_mr_before");
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        sb.push_back(e_rst); chk("rst_async_clear");
        @(posedge clk);
        #1;
        sb.push_back(e_rst); chk("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sb.push_back(e_rst); chk("rst_release_mask");
        @(posedge clk);
        #1;
        step(RR,0,0,e_fw,"rst_fetch_after"); step(RR,0,1,e_fg,"rst_fetch_go");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, 255, max cycles mem_req may stay unacknowledged before fault.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 op  in  7  opcode field of the instruction register.
REQ-005 zero  in  1  ALU zero flag (branch compare result).
REQ-006 mem_ready  in  1  memory acknowledge for the current mem_req.
REQ-007 mem_req  out  1  memory access request.
REQ-008 mem_we  out  1  store qualifier of mem_req.
REQ-009 adr_src  out  1  0: PC, 1: ALU result register as memory address.
REQ-010 ir_write / pc_write / reg_write  out  1 each  register write enables.
REQ-011 alu_src_a  out  2  00 PC, 01 old PC, 10 rs1.
REQ-012 alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4.
REQ-013 alu_op_type  out  2  00 add, 01 subtract/compare, 10 decode funct3/funct7.
REQ-014 result_src  out  3  000 ALU out reg, 001 memory data, 010 ALU result, 011 immediate, 100 old PC+imm.
REQ-015 immsrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-016 illegal / bus_error  out  1 each  one-cycle fault pulses.

Function
REQ-017 Controller SHALL be a FSM: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC.
REQ-018 Every output SHALL default to 0 in every state unless listed for that state.
REQ-019 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10; on mem_ready=1 SHALL assert ir_write=1, pc_write=1 in that cycle and go DECODE; else stay.
REQ-020 DECODE: alu_src_a=01, alu_src_b=01, immsrc=010 (branch target precompute); next state by op: LOAD/STORE->MEMADR, R->EXECR, I-ALU->EXECI, BRANCH->BRANCH, JAL->JAL, JALR->JALR, LUI->LUI, AUIPC->AUIPC.
REQ-021 Unknown op in DECODE SHALL pulse illegal=1 and return to FETCH; no register or memory write.
REQ-022 MEMADR: alu_src_a=10, alu_src_b=01, immsrc=000 for load, 001 for store; ->MEMREAD (load) or MEMWRITE (store).
REQ-023 MEMREAD: mem_req=1, adr_src=1; on mem_ready->MEMWB. MEMWB: result_src=001, reg_write=1 ->FETCH.
REQ-024 MEMWRITE: mem_req=1, mem_we=1, adr_src=1; on mem_ready->FETCH.
REQ-025 EXECR: alu_src_a=10, alu_src_b=00, alu_op_type=10 ->ALUWB. EXECI: same with alu_src_b=01, immsrc=000 ->ALUWB. ALUWB: result_src=000, reg_write=1 ->FETCH.
REQ-026 BRANCH: alu_src_a=10, alu_src_b=00, alu_op_type=01, result_src=000; pc_write=zero ->FETCH.
REQ-027 JAL: immsrc=011, pc_write=1, result_src=000 (PC+4), reg_write=1 ->FETCH; JALR: alu_src_a=10, alu_src_b=01, result_src=010, pc_write=1, reg_write=1 ->FETCH (target LSB cleared by datapath).
REQ-028 LUI: immsrc=100, result_src=011, reg_write=1 ->FETCH. AUIPC: immsrc=100, result_src=100, reg_write=1 ->FETCH.
REQ-029 Wait counter SHALL clear on entry to any mem_req state, increment each cycle mem_req=1 and mem_ready=0; reaching MEM_TIMEOUT SHALL pulse bus_error and go FETCH with no write enable.
REQ-030 mem_req and address selection SHALL stay stable until mem_ready; mem_ready outside mem_req states SHALL be ignored.

Reset
REQ-031 rst_n=0 SHALL immediately force FETCH, counter 0, and all outputs to their FETCH-state values masked by mem_req=0 until first clock after deassertion.
REQ-032 Reset mid-access SHALL abandon the access; no pc_write/ir_write/reg_write pulse.

Structure
REQ-033 State enum, opcode constants and mux-select encodings SHALL live in riscv_pkg.
REQ-034 Sub-module: mem_wait_timer (counter + timeout flag).

Verification
REQ-035 Reset then mem_ready=1 in FETCH: ir_write=pc_write=1 same cycle, DECODE next.
REQ-036 lw with mem_ready delayed 3 cycles: FETCH,DECODE,MEMADR,MEMREAD x4,MEMWB; reg_write=1 only in MEMWB, result_src=001.
REQ-037 beq with zero=1 then zero=0: pc_write=1 then 0 in BRANCH; 3-cycle instruction each.
REQ-038 op=7'h7F: illegal pulses once, FETCH next, no writes.
REQ-039 MEM_TIMEOUT=4, sw with mem_ready held 0: bus_error after 4 wait cycles, FETCH next, mem_we drops.
REQ-040 rst_n low during MEMREAD: outputs cleared asynchronously, FETCH after release.
